// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with a
// start/busy/done handshake. Values beyond the display range saturate to all nines.
module score_bcd_converter #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] max_value(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value(DIGITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_reg;
    logic [BIN_W-1:0]   shift_reg;
    logic [BCD_W-1:0]   scratch_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sat_reg;

    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_next;
    logic [BCD_W-1:0]   all_nines;
    logic [BIN_W-1:0]   shift_next;
    logic               over_max;

    // Add-3 correction is confined to each nibble; no carry crosses digits.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                          ? scratch_reg[4*gi +: 4] + 4'd3
                                          : scratch_reg[4*gi +: 4];
            assign all_nines[4*gi +: 4] = 4'd9;
        end
    endgenerate

    assign scratch_next = {scratch_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
    assign shift_next   = shift_reg << 1;
    assign over_max     = 64'(bin) > MAX_VAL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            sat_reg     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= bin;
                        scratch_reg <= '0;
                        cnt_reg     <= CNT_W'(BIN_W);
                        sat_reg     <= over_max;
                        busy        <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_reg <= scratch_next;
                    shift_reg   <= shift_next;
                    cnt_reg     <= cnt_reg - CNT_W'(1);
                    // Final shift: publish the result on this same edge.
                    if (cnt_reg == CNT_W'(1)) begin
                        bcd       <= sat_reg ? all_nines : scratch_next;
                        overflow  <= sat_reg;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Randomized bench for score_bcd_converter: a transaction-level model predicts
// busy/done/bcd/overflow every cycle, plus literal checks of known conversions.
module tb_score_bcd_converter;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int MAXV   = 9999;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin = '0;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] bcd;
    logic             overflow;

    int n_cmp = 0;
    int n_bad = 0;

    score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Transaction model: a conversion takes BIN_W edges after acceptance.
    int               remaining = 0;
    logic [BCD_W-1:0] pend_bcd = '0;
    logic             pend_ovf = 1'b0;
    logic             exp_busy = 1'b0, exp_done = 1'b0, exp_ovf = 1'b0;
    logic [BCD_W-1:0] exp_bcd = '0;
    bit               model_valid = 1'b0;

    always @(posedge clk) begin
        model_valid = 1'b1;
        if (reset) begin
            remaining = 0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_bcd = '0; exp_ovf = 1'b0;
        end else if (remaining > 0) begin
            remaining--;
            exp_done = (remaining == 0);
            if (remaining == 0) begin
                exp_busy = 1'b0;
                exp_bcd  = pend_bcd;
                exp_ovf  = pend_ovf;
            end
        end else begin
            exp_done = 1'b0;
            if (start) begin
                remaining = BIN_W;
                exp_busy  = 1'b1;
                pend_ovf  = (int'(bin) > MAXV);
                pend_bcd  = pend_ovf ? to_bcd(MAXV) : to_bcd(int'(bin));
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("bcd", 32'(bcd), 32'(exp_bcd));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            if (busy && done) check("busy_done_excl", 32'd1, 32'd0);
        end
    end

    // Single conversion with literal expectations; returns busy-high cycle count.
    task automatic convert(input int v, input logic [BCD_W-1:0] lit_bcd, input logic lit_ovf,
                           output int bcnt);
        int cyc;
        @(negedge clk); start = 1'b1; bin = BIN_W'(v);
        @(negedge clk); start = 1'b0;
        cyc = 0; bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        check("lit_bcd", 32'(bcd), 32'(lit_bcd));
        check("lit_ovf", 32'(overflow), 32'(lit_ovf));
    endtask

    initial begin
        int bc;
        int dones;
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        convert(0, 16'h0000, 1'b0, bc);
        check("busy_cycles", 32'(bc), 32'd14);
        convert(1234, 16'h1234, 1'b0, bc);
        convert(9999, 16'h9999, 1'b0, bc);
        convert(10, 16'h0010, 1'b0, bc);
        convert(12000, 16'h9999, 1'b1, bc);
        convert(5, 16'h0005, 1'b0, bc);

        // start while busy must be ignored; previous result held until done.
        @(negedge clk); start = 1'b1; bin = BIN_W'(42);
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; bin = BIN_W'(77);
        @(negedge clk); start = 1'b0;
        check("hold_bcd", 32'(bcd), 32'h0005);
        dones = 0; cyc = 0;
        while (cyc < 40) begin
            if (done) begin
                dones++;
                check("busy_start_bcd", 32'(bcd), 32'h0042);
            end
            @(negedge clk);
            cyc++;
        end
        check("single_done", 32'(dones), 32'd1);

        // start held high continuously.
        start = 1'b1; bin = BIN_W'(321);
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                check("held_bcd", 32'(bcd), 32'h0321);
            end
        end
        check("held_dones", 32'(dones >= 4), 32'd1);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // reset in the middle of a conversion.
        start = 1'b1; bin = BIN_W'(8888);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bcd", 32'(bcd), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);
        convert(8888, 16'h8888, 1'b0, bc);

        // Randomized traffic, checked every cycle by the model.
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            start = 1'b1;
            bin = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
            for (int g = $urandom_range(0, 20); g > 0; g--) begin
                @(negedge clk);
                start = ($urandom_range(0, 3) == 0);
                bin = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
                reset = ($urandom_range(0, 99) == 0);
            end
            reset = 1'b0;
        end
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
